rom1_read_sequencer: RTL and testbench
======================================

# rom1_read_sequencer

Read sequencer for the dual-bank weight ROM handler (banks selected by `s` = 1 or 2, 256-bit words, one-cycle registered read). On a `start` command it issues a burst of consecutive reads from a chosen bank and base address, and holds the bank select stable until the last word has returned. It buffers returned words in a small credit-controlled FIFO and presents them as a valid/ready stream to the downstream PE-array loader, with `out_last` marking the final word.

## Interface
- `ADDR_W`, 16, ROM word address width (address wraps modulo 2^ADDR_W)
- `DATA_W`, 256, ROM word width
- `LEN_W`, 16, burst length counter width
- `RD_LAT`, 1, cycles from `rom_ena` to valid `rom_data`
- `FIFO_DEPTH`, 4, output buffer entries; must be ≥ RD_LAT+1
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  command strobe; accepted only in IDLE
- `bank`  in  4  ROM bank select; legal values 1 and 2
- `base_addr`  in  ADDR_W  first word address
- `length`  in  LEN_W  words to read; 0 is a legal no-op
- `abort`  in  1  cancels the active burst
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at burst end (normal, empty, error or abort)
- `err`  out  1  one-cycle pulse coincident with `done` when `bank` was illegal
- `rom_ena`  out  1  ROM read enable
- `rom_s`  out  4  bank select driven to the ROM handler
- `rom_addr`  out  ADDR_W  ROM read address
- `rom_data`  in  DATA_W  ROM handler output
- `out_valid`  out  1  stream word valid
- `out_data`  out  DATA_W  stream word (FIFO head)
- `out_last`  out  1  high with the final word of a non-aborted burst
- `out_ready`  in  1  downstream accept

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: on `start`, latch `bank`, `base_addr` and `length`.
  - If the bank is not 1 or 2, go to DONE with `err` set.
  - Else if `length`==0, go to DONE.
  - Else go to ISSUE.
- ISSUE: assert `rom_ena` in any cycle where `fifo_count + inflight < FIFO_DEPTH`.
  - Each issue drives the current address, then increments it; the address wraps from 0xFFFF to 0x0000.
  - After `length` issues, go to DRAIN.
- DRAIN: wait until `inflight`==0 and the FIFO is empty after the last handshake, then go to DONE.
- DONE: pulse `done` (and `err` if latched) for one cycle, then go to IDLE.
- `rom_s` equals the latched bank in ISSUE and DRAIN, and is 0 otherwise. It never changes while any read is in flight.
- `rom_addr` holds its last value when `rom_ena` is low.
- Return capture: an RD_LAT-deep valid shift register tags issued reads. A tagged `rom_data` is written into the FIFO at the end of its cycle. The FIFO handles a simultaneous push and pop with no count change.
- Credit rule: `inflight` counts issued, not-yet-captured reads, so the FIFO can never overflow. With `out_ready` held high the block sustains one word per cycle.
- `out_last` is set when the popped word's sequence index equals `length`-1.
- `abort` in ISSUE or DRAIN:
  - stop issuing immediately and flush the FIFO (`out_valid` low from the next cycle);
  - keep `rom_s` until `inflight` reaches 0, discarding the returns;
  - then go to DONE; no `out_last` is emitted.
- `abort` in IDLE or DONE is ignored. `start` while busy is ignored.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `rom_ena`=0, `rom_s`=0, `rom_addr`=0, `out_valid`=0, `out_last`=0, `out_data`=0. FIFO, counters and state clear; state is IDLE.
- Reset mid-burst discards all in-flight and buffered words. Outputs reach reset values asynchronously.
- Latency (RD_LAT=1): `start` sampled at edge 0.
  - First `rom_ena` in cycle 1.
  - `rom_data` valid in cycle 2.
  - `out_valid` high from cycle 3.
- Burst end: `done` rises one cycle after the handshake of the `out_last` word.
- Empty or error burst: `done` in cycle 1, the cycle after `start`.
- `out_data`/`out_valid` hold stable while `out_valid`=1 and `out_ready`=0.

## Test plan
- Bank 1 burst: `start`, `base_addr`=0x0010, `length`=8, `out_ready`=1.
  - Eight words equal ROM1 addresses 0x10–0x17 on cycles 3–10.
  - `out_last` high on cycle 10; `done` pulses on cycle 11.
- Backpressure: bank 2, `length`=16, `out_ready` toggling 1/0 each cycle.
  - All 16 words arrive in order with none lost or duplicated.
  - `rom_ena` deasserts whenever `fifo_count + inflight` = 4.
  - `rom_s`=2 throughout.
- Wrap and edge commands:
  - `base_addr`=0xFFFE, `length`=4 → addresses FFFE, FFFF, 0000, 0001.
  - `length`=0 → `done` in cycle 1, no `rom_ena`.
  - `bank`=3 → `done` and `err` in cycle 1, `rom_s` stays 0.
- Abort: `length`=32, `abort` after the 5th issue with `out_ready`=0.
  - `out_valid` drops next cycle and no further `rom_ena`.
  - `rom_s` holds until the in-flight read returns; `done` pulses with no `out_last`.
- Reset mid-burst: `rst_n` low during ISSUE with 3 words buffered.
  - All outputs go to reset values immediately.
  - After release, a new `start` produces a clean burst.

Source files
------------

// File: rtl/rom1_read_sequencer.sv
// Burst read sequencer for the dual-bank weight ROM: issues credit-limited reads,
// buffers returns in a small FIFO and streams them to the PE-array loader.
module rom1_read_sequencer #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 256,
  parameter int LEN_W      = 16,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        bank,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rom_ena,
  output logic [3:0]        rom_s,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic [1:0]        dbg_state
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + RD_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [3:0]        bank_q;
  logic [ADDR_W-1:0] next_addr, last_addr;
  logic [LEN_W-1:0]  len_q, issue_cnt, pop_cnt;
  logic              err_q, aborted_q;
  logic [RD_LAT-1:0] tag_sr, tag_sr_next;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  fifo_count, inflight, inflight_next;
  logic              bank_ok, abort_act, issue, capture, push, pop;
  logic              last_issue, drain_empty;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Reads are issued only while buffered plus in-flight words leave room in the FIFO,
  // so a return can always be captured without a stall path back to the ROM.
  always_comb begin
    bank_ok     = (bank == 4'd1) || (bank == 4'd2);
    abort_act   = abort && ((state == S_ISSUE) || (state == S_DRAIN));
    inflight    = CNT_W'($countones(tag_sr));
    issue       = (state == S_ISSUE) && !abort &&
                  ((fifo_count + inflight) < CNT_W'(FIFO_DEPTH));
    tag_sr_next    = tag_sr << 1;
    tag_sr_next[0] = issue;
    inflight_next  = CNT_W'($countones(tag_sr_next));
    capture     = tag_sr[RD_LAT-1];
    push        = capture && !abort_act && !aborted_q;
    last_issue  = issue && (issue_cnt == len_q - LEN_W'(1));
    drain_empty = (inflight == '0) &&
                  ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop));
  end

  // Stream: a word transfers on a cycle where out_valid && out_ready; while stalled the
  // head word and out_valid are held, and out_valid never depends on out_ready.
  assign out_valid = (fifo_count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign pop       = out_valid && out_ready;
  assign out_last  = out_valid && !abort_act && (pop_cnt == len_q - LEN_W'(1));
  assign rom_addr  = issue ? next_addr : last_addr;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = (state != S_IDLE);
    done       = (state == S_DONE);
    err        = (state == S_DONE) && err_q;
    rom_ena    = issue;
    rom_s      = ((state == S_ISSUE) || (state == S_DRAIN)) ? bank_q : 4'd0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (!bank_ok || (length == '0)) state_next = S_DONE;
          else                            state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (abort_act)       state_next = (inflight_next == '0) ? S_DONE : S_DRAIN;
        else if (last_issue) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort_act || aborted_q) begin
          if (inflight_next == '0) state_next = S_DONE;
        end else if (drain_empty) begin
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q     <= '0;
      next_addr  <= '0;
      last_addr  <= '0;
      len_q      <= '0;
      issue_cnt  <= '0;
      pop_cnt    <= '0;
      err_q      <= 1'b0;
      aborted_q  <= 1'b0;
      tag_sr     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if ((state == S_IDLE) && start) begin
        bank_q    <= bank;
        next_addr <= base_addr;
        len_q     <= length;
        issue_cnt <= '0;
        pop_cnt   <= '0;
        err_q     <= !bank_ok;
        aborted_q <= 1'b0;
      end
      if (issue) begin
        last_addr <= next_addr;
        next_addr <= next_addr + ADDR_W'(1);
        issue_cnt <= issue_cnt + LEN_W'(1);
      end
      if (pop)       pop_cnt   <= pop_cnt + LEN_W'(1);
      if (abort_act) aborted_q <= 1'b1;
      tag_sr <= tag_sr_next;
      // Abort empties the buffer; returns still in flight are dropped via aborted_q.
      if (abort_act) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
      end else begin
        if (push) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)  rd_ptr <= ptr_inc(rd_ptr);
        if (push && !pop)      fifo_count <= fifo_count + CNT_W'(1);
        else if (pop && !push) fifo_count <= fifo_count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rom_data;
  end

endmodule

// File: tb/tb_rom1_read_sequencer.sv
// Bench for rom1_read_sequencer: directed bursts with literal timing pins plus
// random traffic checked every cycle against a transaction-level model.
module tb_rom1_read_sequencer;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   bank = '0;
  logic [15:0]  base_addr = '0;
  logic [15:0]  length = '0;
  logic         abort = 1'b0;
  logic         out_ready = 1'b0;
  logic [255:0] rom_data = '0;
  logic         busy, done, err, rom_ena, out_valid, out_last;
  logic [3:0]   rom_s;
  logic [15:0]  rom_addr;
  logic [255:0] out_data;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  rom1_read_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bank(bank), .base_addr(base_addr),
    .length(length), .abort(abort), .busy(busy), .done(done), .err(err),
    .rom_ena(rom_ena), .rom_s(rom_s), .rom_addr(rom_addr), .rom_data(rom_data),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  function automatic logic [255:0] rom_word(input logic [3:0] s, input logic [15:0] a);
    logic [255:0] w;
    for (int i = 0; i < 8; i++)
      w[i*32 +: 32] = {s, 4'(i), a ^ 16'(i * 16'h1357), 8'hA5};
    return w;
  endfunction

  // ROM handler: one-cycle registered read
  always @(posedge clk) if (rom_ena) rom_data <= rom_word(rom_s, rom_addr);

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // behavioural model: phase 0 idle, 1 bursting, 2 done pulse
  int          m_phase = 0;
  bit          m_err = 0;
  logic [3:0]  m_bank = '0;
  logic [15:0] m_base = '0, m_last_addr = '0;
  int          m_len = 0, m_issued = 0, m_popped = 0, m_cyc = 0;
  int          m_q[$];   // issue cycles of words issued but not yet delivered

  function automatic int m_avail();
    int n = 0;
    foreach (m_q[i]) if (m_q[i] + 2 <= m_cyc) n++;
    return n;
  endfunction

  logic         e_ena, e_valid, e_last;
  logic [3:0]   e_s;
  logic [15:0]  e_addr;
  logic [255:0] e_data;

  // compare process: inputs are stable at negedge+2, outputs settled
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        check("rst_busy", busy, 0);         check("rst_done", done, 0);
        check("rst_err", err, 0);           check("rst_rom_ena", rom_ena, 0);
        check("rst_rom_s", rom_s, 0);       check("rst_rom_addr", rom_addr, 0);
        check("rst_out_valid", out_valid, 0); check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        m_phase = 0; m_err = 0; m_last_addr = '0; m_q.delete();
        m_issued = 0; m_popped = 0; m_len = 0;
      end else begin
        e_ena = 0; e_s = '0; e_valid = 0; e_last = 0; e_data = '0;
        if (m_phase == 1) begin
          e_ena   = (m_issued < m_len) && (m_q.size() < DEPTH) && !abort;
          e_s     = m_bank;
          e_valid = m_avail() > 0;
          if (e_valid) begin
            e_data = rom_word(m_bank, m_base + 16'(m_popped));
            e_last = (m_popped == m_len - 1) && !abort;
          end
        end
        e_addr = e_ena ? m_base + 16'(m_issued) : m_last_addr;
        check("busy", busy, m_phase != 0);
        check("done", done, m_phase == 2);
        check("err", err, (m_phase == 2) && m_err);
        check("rom_ena", rom_ena, e_ena);
        check("rom_s", rom_s, e_s);
        check("rom_addr", rom_addr, e_addr);
        check("out_valid", out_valid, e_valid);
        check("out_last", out_last, e_last);
        if (e_valid) check("out_data", out_data, e_data);
        case (m_phase)
          0: if (start) begin
            m_bank = bank; m_base = base_addr; m_len = int'(length);
            m_issued = 0; m_popped = 0; m_q.delete();
            m_err = !((bank == 4'd1) || (bank == 4'd2));
            m_phase = (m_err || (length == 0)) ? 2 : 1;
          end
          1: if (abort) begin
            m_phase = 2; m_q.delete();
          end else begin
            if (e_valid && out_ready) begin m_popped++; void'(m_q.pop_front()); end
            if (e_ena) begin m_q.push_back(m_cyc); m_issued++; m_last_addr = e_addr; end
            if (m_popped == m_len) m_phase = 2;
          end
          default: m_phase = 0;
        endcase
      end
      m_cyc++;
    end
  end

  // driver: apply inputs at negedge, return at negedge+3 for direct observation
  task automatic drive(input logic st, input logic [3:0] b, input logic [15:0] a,
                       input logic [15:0] l, input logic ab, input logic rdy);
    @(negedge clk);
    start = st; bank = b; base_addr = a; length = l; abort = ab; out_ready = rdy;
    #3;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive(0, 4'd0, 16'h0, 16'h0, 0, 1);
  endtask

  int first_k, last_k, done_k, nwords, nena, ab_k;
  logic [15:0] addr_seen[$];
  logic [15:0] wrap_exp[4];
  logic [3:0]  bank_tbl[9];

  initial begin
    wrap_exp = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    bank_tbl = '{4'd1, 4'd2, 4'd1, 4'd2, 4'd1, 4'd2, 4'd3, 4'd0, 4'd15};
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    idle_cycles(2);

    // bank 1, base 0x10, length 8, ready high
    first_k = -1; last_k = -1; done_k = -1; nwords = 0;
    drive(1, 4'd1, 16'h0010, 16'd8, 0, 1);
    for (int k = 1; k <= 14; k++) begin
      drive(0, 4'd0, 16'h0, 16'h0, 0, 1);
      if (out_valid) begin
        nwords++;
        if (first_k < 0) begin
          first_k = k;
          check("b1_first_word_lane0", out_data[31:0], 32'h100010A5);
        end
      end
      if (out_last) last_k = k;
      if (done && done_k < 0) done_k = k;
    end
    check("b1_first_valid_cycle", first_k, 3);
    check("b1_last_cycle", last_k, 10);
    check("b1_done_cycle", done_k, 11);
    check("b1_word_count", nwords, 8);

    // bank 2, length 16, ready toggling
    nwords = 0; done_k = -1;
    drive(1, 4'd2, 16'h1000, 16'd16, 0, 1);
    for (int k = 1; k <= 80 && done_k < 0; k++) begin
      drive(0, 4'd0, 16'h0, 16'h0, 0, k[0]);
      if (out_valid && out_ready) nwords++;
      if (done) done_k = k;
    end
    check("bp_word_count", nwords, 16);
    check("bp_done_seen", done_k > 0, 1);
    idle_cycles(2);

    // address wrap
    addr_seen.delete();
    drive(1, 4'd1, 16'hFFFE, 16'd4, 0, 1);
    for (int k = 1; k <= 10; k++) begin
      drive(0, 4'd0, 16'h0, 16'h0, 0, 1);
      if (rom_ena) addr_seen.push_back(rom_addr);
    end
    check("wrap_issue_count", addr_seen.size(), 4);
    for (int i = 0; i < 4 && i < addr_seen.size(); i++)
      check($sformatf("wrap_addr%0d", i), addr_seen[i], wrap_exp[i]);

    // length 0 and illegal bank
    nena = 0;
    drive(1, 4'd2, 16'h0100, 16'd0, 0, 1);
    drive(0, 4'd0, 16'h0, 16'h0, 0, 1);
    check("len0_done_cycle1", done, 1);
    if (rom_ena) nena++;
    idle_cycles(1);
    drive(1, 4'd3, 16'h0100, 16'd5, 0, 1);
    if (rom_ena) nena++;
    drive(0, 4'd0, 16'h0, 16'h0, 0, 1);
    check("bad_bank_done", done, 1);
    check("bad_bank_err", err, 1);
    check("bad_bank_rom_s", rom_s, 0);
    if (rom_ena) nena++;
    idle_cycles(1);
    check("len0_bad_bank_no_ena", nena, 0);

    // abort after the 5th issue
    nena = 0; ab_k = -1; last_k = -1;
    drive(1, 4'd1, 16'h0200, 16'd32, 0, 1);
    for (int k = 1; k <= 40 && ab_k < 0; k++) begin
      drive(0, 4'd0, 16'h0, 16'h0, 0, 1);
      if (rom_ena) nena++;
      if (out_last) last_k = k;
      if (nena == 5) ab_k = k;
    end
    drive(0, 4'd0, 16'h0, 16'h0, 1, 0);
    check("abort_no_ena", rom_ena, 0);
    check("abort_rom_s_held", rom_s, 1);
    drive(0, 4'd0, 16'h0, 16'h0, 0, 0);
    check("abort_valid_drop", out_valid, 0);
    check("abort_done", done, 1);
    check("abort_no_last", out_last, 0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 4'd0, 16'h0, 16'h0, 0, 0);
      if (rom_ena) nena++;
    end
    check("abort_issue_total", nena, 5);
    check("abort_last_never", last_k, -1);

    // reset with words buffered
    drive(1, 4'd2, 16'h0300, 16'd32, 0, 0);
    for (int k = 1; k <= 20 && !(m_phase == 1 && m_avail() == 3); k++)
      drive(0, 4'd0, 16'h0, 16'h0, 0, 0);
    check("rst_precondition", m_avail(), 3);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #2;
    check("async_rst_busy", busy, 0);
    check("async_rst_valid", out_valid, 0);
    check("async_rst_rom_s", rom_s, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    nwords = 0; done_k = -1;
    drive(1, 4'd1, 16'h0040, 16'd6, 0, 1);
    for (int k = 1; k <= 20 && done_k < 0; k++) begin
      drive(0, 4'd0, 16'h0, 16'h0, 0, 1);
      if (out_valid) nwords++;
      if (done) done_k = k;
    end
    check("post_rst_words", nwords, 6);
    check("post_rst_done_cycle", done_k, 9);

    // random traffic
    begin
      int bias = 3;
      for (int c = 0; c < 3000; c++) begin
        logic [15:0] a, l;
        if (c % 200 == 0) bias = $urandom_range(0, 3);
        a = ($urandom_range(0, 3) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15))
                                        : 16'($urandom);
        l = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3))
                                        : 16'($urandom_range(4, 40));
        drive($urandom_range(0, 7) == 0, bank_tbl[$urandom_range(0, 8)], a, l,
              $urandom_range(0, 79) == 0, $urandom_range(0, 3) <= bias);
      end
    end
    for (int k = 0; k < 200 && m_phase != 0; k++) idle_cycles(1);
    check("final_idle", m_phase, 0);
    idle_cycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
